// File: rtl/tmma_load_seq.sv
// TMMA operand-load sequencer: issues A then B row reads for one tile,
// buffers in-order returns and streams tagged rows to the array feeder.
module tmma_load_seq #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 512,
    parameter int ROWS       = 16,
    parameter int ROW_STRIDE = 256,
    parameter int MAX_OUTST  = 8,
    parameter int TYPE_WIDTH = 3,
    parameter int TMMA_TYPE  = 1,
    parameter int PREC_WIDTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    issue_valid_i,
    output logic                    issue_ready_o,
    input  logic [TYPE_WIDTH-1:0]   issue_type_i,
    input  logic [ADDR_WIDTH-1:0]   issue_addr0_i,
    input  logic [ADDR_WIDTH-1:0]   issue_addr1_i,
    input  logic [PREC_WIDTH-1:0]   issue_prec_i,
    input  logic                    issue_acc_i,
    output logic                    ar_valid_o,
    input  logic                    ar_ready_i,
    output logic [ADDR_WIDTH-1:0]   ar_addr_o,
    input  logic                    r_valid_i,
    output logic                    r_ready_o,
    input  logic [DATA_WIDTH-1:0]   r_data_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic                    out_sel_o,
    output logic [$clog2(ROWS)-1:0] out_row_o,
    output logic [DATA_WIDTH-1:0]   out_data_o,
    output logic [PREC_WIDTH-1:0]   out_prec_o,
    output logic                    out_acc_o,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(2 * ROWS) + 1;
    localparam int IW = $clog2(MAX_OUTST + 1);
    localparam int PW = $clog2(MAX_OUTST);

    localparam logic [CW-1:0] CNT_LAST = CW'(2 * ROWS - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(ROWS);
    localparam logic [IW-1:0] CREDITS  = IW'(MAX_OUTST);
    localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTST - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e state_q;
    logic   rdy_q, busy_q, done_q;

    logic [ADDR_WIDTH-1:0] addr0_q, addr0_d;
    logic [ADDR_WIDTH-1:0] addr1_q, addr1_d;
    logic [PREC_WIDTH-1:0] prec_q, prec_d;
    logic                  acc_q, acc_d;
    logic [CW-1:0]         ar_cnt_q, ar_cnt_d;
    logic [CW-1:0]         pop_cnt_q, pop_cnt_d;
    logic [IW-1:0]         infl_q, infl_d;

    logic [DATA_WIDTH-1:0] mem_q [MAX_OUTST];
    logic [PW-1:0]         wr_q, wr_d;
    logic [PW-1:0]         rd_q, rd_d;
    logic [IW-1:0]         fcnt_q, fcnt_d;

    logic accept, ar_hs, out_hs, push, pop;
    logic fifo_empty, fifo_full;
    logic [ADDR_WIDTH-1:0] ar_base, ar_off;

    assign accept = issue_valid_i && rdy_q
                 && (issue_type_i == TYPE_WIDTH'(TMMA_TYPE));
    assign ar_hs  = ar_valid_o && ar_ready_i;
    assign out_hs = out_valid_o && out_ready_i;
    assign push   = r_valid_i && r_ready_o;
    assign pop    = out_hs;

    assign fifo_empty = (fcnt_q == '0);
    assign fifo_full  = (fcnt_q == CREDITS);

    assign issue_ready_o = rdy_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

    // Credit gate: never more reads outstanding than FIFO slots.
    assign ar_valid_o = (state_q == S_REQ) && (infl_q < CREDITS);
    assign ar_base    = (ar_cnt_q < CNT_HALF) ? addr0_q : addr1_q;
    assign ar_off     = ADDR_WIDTH'(ar_cnt_q[RW-1:0])
                      * ADDR_WIDTH'(ROW_STRIDE);
    assign ar_addr_o  = ar_base + ar_off;

    assign r_ready_o   = !fifo_full;
    assign out_valid_o = !fifo_empty;
    assign out_data_o  = fifo_empty ? '0 : mem_q[rd_q];
    assign out_sel_o   = (pop_cnt_q >= CNT_HALF);
    assign out_row_o   = pop_cnt_q[RW-1:0];
    assign out_prec_o  = prec_q;
    assign out_acc_o   = acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_q <= S_REQ;
                        rdy_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (ar_hs && ar_cnt_q == CNT_LAST) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (out_hs && pop_cnt_q == CNT_LAST) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    rdy_q   <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    rdy_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        addr0_d   = addr0_q;
        addr1_d   = addr1_q;
        prec_d    = prec_q;
        acc_d     = acc_q;
        ar_cnt_d  = ar_cnt_q;
        pop_cnt_d = pop_cnt_q;
        infl_d    = infl_q;
        if (accept) begin
            addr0_d   = issue_addr0_i;
            addr1_d   = issue_addr1_i;
            prec_d    = issue_prec_i;
            acc_d     = issue_acc_i;
            ar_cnt_d  = '0;
            pop_cnt_d = '0;
            infl_d    = '0;
        end else begin
            if (ar_hs) begin
                ar_cnt_d = ar_cnt_q + CW'(1);
            end
            if (out_hs) begin
                pop_cnt_d = pop_cnt_q + CW'(1);
            end
            if (ar_hs && !out_hs) begin
                infl_d = infl_q + IW'(1);
            end else if (!ar_hs && out_hs) begin
                infl_d = infl_q - IW'(1);
            end
        end
    end

    always_comb begin
        wr_d   = wr_q;
        rd_d   = rd_q;
        fcnt_d = fcnt_q;
        if (push) begin
            wr_d = (wr_q == PTR_LAST) ? '0 : wr_q + PW'(1);
        end
        if (pop) begin
            rd_d = (rd_q == PTR_LAST) ? '0 : rd_q + PW'(1);
        end
        if (push && !pop) begin
            fcnt_d = fcnt_q + IW'(1);
        end else if (!push && pop) begin
            fcnt_d = fcnt_q - IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr0_q   <= '0;
            addr1_q   <= '0;
            prec_q    <= '0;
            acc_q     <= 1'b0;
            ar_cnt_q  <= '0;
            pop_cnt_q <= '0;
            infl_q    <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            fcnt_q    <= '0;
        end else begin
            addr0_q   <= addr0_d;
            addr1_q   <= addr1_d;
            prec_q    <= prec_d;
            acc_q     <= acc_d;
            ar_cnt_q  <= ar_cnt_d;
            pop_cnt_q <= pop_cnt_d;
            infl_q    <= infl_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            fcnt_q    <= fcnt_d;
        end
    end

    // Row storage needs no reset; the output mux hides it while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= r_data_i;
        end
    end

endmodule

// File: tb/tb_tmma_load_seq.sv
// Scoreboard bench for tmma_load_seq: expected AR addresses and rows are
// queued at issue time and checked by an independent negedge monitor.
module tb_tmma_load_seq;

    localparam int AW = 64;
    localparam int DW = 512;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          issue_valid_i = 1'b0;
    logic          issue_ready_o;
    logic [2:0]    issue_type_i = '0;
    logic [AW-1:0] issue_addr0_i = '0;
    logic [AW-1:0] issue_addr1_i = '0;
    logic [1:0]    issue_prec_i = '0;
    logic          issue_acc_i = 1'b0;
    logic          ar_valid_o;
    logic          ar_ready_i = 1'b0;
    logic [AW-1:0] ar_addr_o;
    logic          r_valid_i = 1'b0;
    logic          r_ready_o;
    logic [DW-1:0] r_data_i = '0;
    logic          out_valid_o;
    logic          out_ready_i = 1'b0;
    logic          out_sel_o;
    logic [3:0]    out_row_o;
    logic [DW-1:0] out_data_o;
    logic [1:0]    out_prec_o;
    logic          out_acc_o;
    logic          busy_o;
    logic          done_o;

    tmma_load_seq dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_type_i(issue_type_i), .issue_addr0_i(issue_addr0_i),
        .issue_addr1_i(issue_addr1_i), .issue_prec_i(issue_prec_i),
        .issue_acc_i(issue_acc_i),
        .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i),
        .ar_addr_o(ar_addr_o),
        .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_sel_o(out_sel_o), .out_row_o(out_row_o),
        .out_data_o(out_data_o), .out_prec_o(out_prec_o),
        .out_acc_o(out_acc_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          sel;
        logic [3:0]    row;
        logic [DW-1:0] data;
        logic [1:0]    prec;
        logic          acc;
    } exp_t;

    typedef struct {
        logic [AW-1:0] addr;
        int            due;
    } rsp_t;

    logic [AW-1:0] exp_ar[$];
    exp_t          exp_out[$];
    rsp_t          rsp[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int ar_hs_cnt = 0;
    int done_cnt = 0;
    logic ar_mode = 1'b0;
    logic out_en = 1'b1;

    logic          ar_hold = 1'b0;
    logic [AW-1:0] hold_addr = '0;
    logic          out_hold = 1'b0;
    logic          hold_sel = 1'b0;
    logic [3:0]    hold_row = '0;
    logic [DW-1:0] hold_data = '0;

    function automatic logic [DW-1:0] mkdata(input logic [AW-1:0] a);
        return {8{a ^ 64'h5A5A_0000_C3C3_0000}};
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic expect_tile(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                               input logic [1:0] pr, input logic ac);
        for (int i = 0; i < 32; i++) begin
            logic [AW-1:0] a;
            exp_t e;
            a = (i < 16 ? a0 : a1) + 64'(i % 16) * 64'd256;
            exp_ar.push_back(a);
            e.sel  = (i >= 16);
            e.row  = 4'(i % 16);
            e.data = mkdata(a);
            e.prec = pr;
            e.acc  = ac;
            exp_out.push_back(e);
        end
    endtask

    task automatic issue(input logic [2:0] ty, input logic [AW-1:0] a0,
                         input logic [AW-1:0] a1, input logic [1:0] pr,
                         input logic ac);
        int k;
        @(posedge clk);
        #1;
        issue_valid_i = 1'b1;
        issue_type_i  = ty;
        issue_addr0_i = a0;
        issue_addr1_i = a1;
        issue_prec_i  = pr;
        issue_acc_i   = ac;
        k = 0;
        @(negedge clk);
        while (!issue_ready_o && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("issue_ready", issue_ready_o, 1);
        @(posedge clk);
        #1;
        issue_valid_i = 1'b0;
    endtask

    task automatic wait_done(input int base);
        int k;
        k = 0;
        while (done_cnt == base && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("done_seen", done_cnt != base, 1);
    endtask

    // Memory model: returns each accepted AR two cycles later, in order.
    always @(posedge clk) begin
        cyc++;
        #1;
        ar_ready_i  = ar_mode ? cyc[0] : 1'b1;
        out_ready_i = out_en;
        if (rsp.size() > 0 && rsp[0].due <= cyc) begin
            r_valid_i = 1'b1;
            r_data_i  = mkdata(rsp[0].addr);
        end else begin
            r_valid_i = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            ar_hold  = 1'b0;
            out_hold = 1'b0;
        end else begin
            if (ar_hold) begin
                chk("ar_hold_valid", ar_valid_o, 1);
                chk("ar_hold_addr", ar_addr_o, hold_addr);
            end
            ar_hold   = ar_valid_o && !ar_ready_i;
            hold_addr = ar_addr_o;
            if (ar_valid_o && ar_ready_i) begin
                ar_hs_cnt++;
                if (exp_ar.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL ar_unexpected: got %0h expected none",
                             ar_addr_o);
                end else begin
                    chk("ar_addr", ar_addr_o, exp_ar.pop_front());
                end
                rsp.push_back('{ar_addr_o, cyc + 2});
            end
            if (r_valid_i && r_ready_o && rsp.size() > 0) begin
                rsp.delete(0);
            end
            if (out_hold) begin
                chk("out_hold_valid", out_valid_o, 1);
                chk("out_hold_sel", out_sel_o, hold_sel);
                chk("out_hold_row", out_row_o, hold_row);
                chk("out_hold_data", out_data_o, hold_data);
            end
            out_hold  = out_valid_o && !out_ready_i;
            hold_sel  = out_sel_o;
            hold_row  = out_row_o;
            hold_data = out_data_o;
            if (out_valid_o && out_ready_i) begin
                if (exp_out.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL out_unexpected: got row %0d expected none",
                             out_row_o);
                end else begin
                    exp_t e;
                    e = exp_out.pop_front();
                    chk("out_sel", out_sel_o, e.sel);
                    chk("out_row", out_row_o, e.row);
                    chk("out_data", out_data_o, e.data);
                    chk("out_prec", out_prec_o, e.prec);
                    chk("out_acc", out_acc_o, e.acc);
                end
            end
            if (done_o) begin
                done_cnt++;
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_issue_ready"}, issue_ready_o, 1);
        chk({tag, "_ar_valid"}, ar_valid_o, 0);
        chk({tag, "_out_valid"}, out_valid_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_r_ready"}, r_ready_o, 1);
        chk({tag, "_ar_addr"}, ar_addr_o, 0);
        chk({tag, "_out_data"}, out_data_o, 0);
    endtask

    initial begin
        int base;
        int k;

        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk_reset_vals("rst");

        // Nominal tile
        base = done_cnt;
        expect_tile(64'h1000, 64'h8000, 2'd2, 1'b1);
        issue(3'd1, 64'h1000, 64'h8000, 2'd2, 1'b1);
        wait_done(base);
        repeat (5) @(negedge clk);
        chk("t1_done_once", done_cnt, base + 1);
        chk("t1_ar_drained", exp_ar.size(), 0);
        chk("t1_out_drained", exp_out.size(), 0);
        chk("t1_idle_busy", busy_o, 0);

        // Feeder stalled: credits cap issue at MAX_OUTST
        out_en = 1'b0;
        base = ar_hs_cnt;
        expect_tile(64'h20000, 64'h30000, 2'd1, 1'b0);
        issue(3'd1, 64'h20000, 64'h30000, 2'd1, 1'b0);
        repeat (40) @(negedge clk);
        chk("credit_ar_count", ar_hs_cnt - base, 8);
        chk("credit_ar_valid", ar_valid_o, 0);
        chk("credit_busy", busy_o, 1);
        base = done_cnt;
        out_en = 1'b1;
        wait_done(base);
        chk("t2_out_drained", exp_out.size(), 0);

        // AR stalls every other cycle
        ar_mode = 1'b1;
        base = done_cnt;
        expect_tile(64'h4000, 64'hC000, 2'd3, 1'b0);
        issue(3'd1, 64'h4000, 64'hC000, 2'd3, 1'b0);
        wait_done(base);
        chk("t3_ar_drained", exp_ar.size(), 0);
        ar_mode = 1'b0;

        // Non-TMMA type is swallowed
        base = ar_hs_cnt;
        k = done_cnt;
        issue(3'd2, 64'hDEAD_0000, 64'hBEEF_0000, 2'd1, 1'b1);
        repeat (10) @(negedge clk);
        chk("nontmma_busy", busy_o, 0);
        chk("nontmma_no_ar", ar_hs_cnt - base, 0);
        chk("nontmma_no_done", done_cnt, k);
        chk("nontmma_ready", issue_ready_o, 1);

        // Second instruction held during a tile
        base = done_cnt;
        expect_tile(64'h70000, 64'h90000, 2'd0, 1'b1);
        issue(3'd1, 64'h70000, 64'h90000, 2'd0, 1'b1);
        expect_tile(64'hA000, 64'hB000, 2'd3, 1'b1);
        issue_valid_i = 1'b1;
        issue_type_i  = 3'd1;
        issue_addr0_i = 64'hA000;
        issue_addr1_i = 64'hB000;
        issue_prec_i  = 2'd3;
        issue_acc_i   = 1'b1;
        @(negedge clk);
        chk("held_not_ready", issue_ready_o, 0);
        k = 0;
        while (!issue_ready_o && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("held_after_done", done_cnt, base + 1);
        @(posedge clk);
        #1;
        issue_valid_i = 1'b0;
        wait_done(base + 1);
        chk("t5_out_drained", exp_out.size(), 0);

        // Abort mid-tile
        base = ar_hs_cnt;
        expect_tile(64'h50000, 64'h60000, 2'd2, 1'b0);
        issue(3'd1, 64'h50000, 64'h60000, 2'd2, 1'b0);
        k = 0;
        while (ar_hs_cnt - base < 5 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("abort_five_ar", ar_hs_cnt - base, 5);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_vals("abort");
        exp_ar.delete();
        exp_out.delete();
        rsp.delete();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        base = done_cnt;
        expect_tile(64'h50000, 64'h60000, 2'd2, 1'b0);
        issue(3'd1, 64'h50000, 64'h60000, 2'd2, 1'b0);
        wait_done(base);
        repeat (5) @(negedge clk);
        chk("final_ar_drained", exp_ar.size(), 0);
        chk("final_out_drained", exp_out.size(), 0);
        chk("final_busy", busy_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
